conv_frame_collector: RTL and testbench

//   Sink for the convolution core's output pixel stream (out_valid/output_pixel).

---
 rtl/conv_pkg.sv | 17 +
 rtl/frame_ram.sv | 28 ++
 rtl/conv_frame_collector.sv | 153 +++++++++++++++
 tb/tb_conv_frame_collector.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution capture path.
// Pixel width, default kernel size and the collector state type.
package conv_pkg;

    localparam int PIX_W = 8;
    localparam int K_DEF = 3;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } collect_state_t;

    function automatic int out_dim(input int n, input int k);
        return n - k + 1;
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one write port, one synchronous read port.
// Read data only changes on a read request, so it holds between reads.
module frame_ram #(
    parameter int DEPTH = 24,
    parameter int AW    = 5,
    parameter int DW    = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/conv_frame_collector.sv
// Captures one valid-region frame from the conv core and holds it for
// random-access readback until the consumer releases it.
module conv_frame_collector
    import conv_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 6,
    parameter int K     = K_DEF,
    localparam int OUT_W = out_dim(IMG_W, K),
    localparam int OUT_H = out_dim(IMG_H, K),
    localparam int N_PIX = OUT_W * OUT_H,
    localparam int AW    = $clog2(N_PIX)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    input  logic [PIX_W-1:0] in_pixel_i,
    input  logic             release_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [PIX_W-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic [AW-1:0]    pixel_x_o,
    output logic [AW-1:0]    pixel_y_o,
    output logic             buf_full_o,
    output logic             frame_done_o,
    output logic             overflow_o,
    output logic [15:0]      frame_count_o
);

    collect_state_t   state_q, state_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [AW-1:0]    x_q, x_d;
    logic [AW-1:0]    y_q, y_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             rd_valid_q, rd_valid_d;
    logic             oor_q, oor_d;
    logic [PIX_W-1:0] last_q, last_d;
    logic [PIX_W-1:0] ram_rdata;
    logic             we;
    logic             re;
    logic             last_pix;

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        x_d        = x_q;
        y_d        = y_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        rd_valid_d = 1'b0;
        oor_d      = oor_q;
        last_d     = rd_valid_q ? rd_data_o : last_q;
        we         = 1'b0;
        re         = 1'b0;
        last_pix   = (wr_addr_q == AW'(N_PIX - 1));

        unique case (state_q)
            COLLECT: begin
                if (in_valid_i) begin
                    we = 1'b1;
                    if (last_pix) begin
                        state_d   = HOLD;
                        done_d    = 1'b1;
                        cnt_d     = cnt_q + 16'd1;
                        wr_addr_d = '0;
                        x_d       = '0;
                        y_d       = '0;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                        if (x_q == AW'(OUT_W - 1)) begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                // A dropped pixel outranks release when clearing overflow
                if (in_valid_i) begin
                    ovf_d = 1'b1;
                end else if (release_i) begin
                    ovf_d = 1'b0;
                end
                if (release_i) begin
                    state_d = COLLECT;
                end
                if (rd_en_i) begin
                    rd_valid_d = 1'b1;
                    oor_d      = (32'(rd_addr_i) >= N_PIX);
                    re         = !oor_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= COLLECT;
            wr_addr_q  <= '0;
            x_q        <= '0;
            y_q        <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            oor_q      <= 1'b0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            oor_q      <= oor_d;
            last_q     <= last_d;
        end
    end

    frame_ram #(
        .DEPTH (N_PIX),
        .AW    (AW),
        .DW    (PIX_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (wr_addr_q),
        .wdata_i (in_pixel_i),
        .re_i    (re),
        .raddr_i (rd_addr_i),
        .rdata_o (ram_rdata)
    );

    // RAM has no reset, so the held value lives in last_q
    assign rd_data_o     = rd_valid_q ? (oor_q ? '0 : ram_rdata) : last_q;
    assign rd_valid_o    = rd_valid_q;
    assign pixel_x_o     = x_q;
    assign pixel_y_o     = y_q;
    assign buf_full_o    = (state_q == HOLD);
    assign frame_done_o  = done_q;
    assign overflow_o    = ovf_q;
    assign frame_count_o = cnt_q;

endmodule

// File: tb/tb_conv_frame_collector.sv
// Bench for conv_frame_collector: directed scenarios plus random traffic,
// all outputs checked every cycle against a frame-level reference model.
module tb_conv_frame_collector;

    localparam int OUT_W = 6;
    localparam int N_PIX = 24;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [7:0]    in_pixel;
    logic          rel;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [AW-1:0] pixel_x;
    logic [AW-1:0] pixel_y;
    logic          buf_full;
    logic          frame_done;
    logic          overflow;
    logic [15:0]   frame_count;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    conv_frame_collector #(
        .IMG_W (8),
        .IMG_H (6),
        .K     (3)
    ) dut (
        .clk_i         (clk),
        .reset_i       (rst_n),
        .in_valid_i    (in_valid),
        .in_pixel_i    (in_pixel),
        .release_i     (rel),
        .rd_en_i       (rd_en),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .rd_valid_o    (rd_valid),
        .pixel_x_o     (pixel_x),
        .pixel_y_o     (pixel_y),
        .buf_full_o    (buf_full),
        .frame_done_o  (frame_done),
        .overflow_o    (overflow),
        .frame_count_o (frame_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: frame seen as a count of captured pixels and a held flag
    logic [7:0] m_mem [N_PIX];
    int         m_n    = 0;
    bit         m_hold = 0;
    bit         m_done = 0;
    bit         m_ovf  = 0;
    int         m_cnt  = 0;
    bit         m_rdv  = 0;
    logic [7:0] m_rdd  = 8'h00;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_n = 0; m_hold = 0; m_done = 0; m_ovf = 0;
            m_cnt = 0; m_rdv = 0; m_rdd = 8'h00;
        end else begin
            m_done = 0;
            m_rdv  = 0;
            if (m_hold) begin
                if (rd_en) begin
                    m_rdv = 1;
                    m_rdd = (int'(rd_addr) < N_PIX) ? m_mem[rd_addr] : 8'h00;
                end
                if (rel) begin
                    m_ovf  = in_valid;
                    m_hold = 0;
                end else if (in_valid) begin
                    m_ovf = 1;
                end
            end else if (in_valid) begin
                m_mem[m_n] = in_pixel;
                m_n++;
                if (m_n == N_PIX) begin
                    m_n    = 0;
                    m_hold = 1;
                    m_done = 1;
                    m_cnt  = (m_cnt + 1) % 65536;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_valid", rd_valid, m_rdv);
            chk("rd_data", rd_data, m_rdd);
            chk("pixel_x", pixel_x, m_n % OUT_W);
            chk("pixel_y", pixel_y, m_n / OUT_W);
            chk("buf_full", buf_full, m_hold);
            chk("frame_done", frame_done, m_done);
            chk("overflow", overflow, m_ovf);
            chk("frame_count", frame_count, m_cnt);
        end
    end

    task automatic send(input logic [7:0] p);
        in_valid = 1'b1;
        in_pixel = p;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic rd(input int a);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        @(negedge clk);
        rd_en   = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".rd_data"}, rd_data, 0);
        chk({tag, ".rd_valid"}, rd_valid, 0);
        chk({tag, ".pixel_x"}, pixel_x, 0);
        chk({tag, ".pixel_y"}, pixel_y, 0);
        chk({tag, ".buf_full"}, buf_full, 0);
        chk({tag, ".frame_done"}, frame_done, 0);
        chk({tag, ".overflow"}, overflow, 0);
        chk({tag, ".frame_count"}, frame_count, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_pixel = '0;
        rel = 1'b0; rd_en = 1'b0; rd_addr = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        chk_en = 1;
        rst_n  = 1'b1;
        @(negedge clk);

        // Back-to-back frame 0..23
        for (int i = 0; i < N_PIX; i++) send(8'(i));
        chk("t1.frame_done", frame_done, 1);
        chk("t1.buf_full", buf_full, 1);
        chk("t1.frame_count", frame_count, 1);
        for (int i = 0; i < N_PIX; i++) begin
            rd(i);
            chk("t1.rd_data", rd_data, i);
            chk("t1.rd_valid", rd_valid, 1);
        end

        // Pixels while held are dropped
        for (int i = 0; i < 3; i++) send(8'hFF);
        chk("t3.overflow", overflow, 1);
        rd(0);
        chk("t3.mem0", rd_data, 0);
        rel = 1'b1;
        @(negedge clk);
        rel = 1'b0;
        chk("t3.buf_full", buf_full, 0);
        chk("t3.overflow_clr", overflow, 0);

        // Sparse in_valid
        for (int i = 0; i < N_PIX; i++) begin
            send(8'(i));
            if (i == 6) begin
                chk("t2.pixel_x", pixel_x, 1);
                chk("t2.pixel_y", pixel_y, 1);
            end
            chk("t2.frame_done", frame_done, (i == N_PIX - 1) ? 1 : 0);
            @(negedge clk);
        end
        chk("t2.frame_count", frame_count, 2);
        for (int i = 0; i < N_PIX; i++) begin
            rd(i);
            chk("t2.rd_data", rd_data, i);
        end

        // Out-of-range read
        rd(24);
        chk("t5.oor_data", rd_data, 0);
        chk("t5.oor_valid", rd_valid, 1);

        // Read with release in the same cycle
        rel = 1'b1;
        rd(5);
        rel = 1'b0;
        chk("t6.rd_data", rd_data, 5);
        chk("t6.rd_valid", rd_valid, 1);
        chk("t6.buf_full", buf_full, 0);
        rd(3);
        chk("t5.collect_valid", rd_valid, 0);
        chk("t5.collect_hold", rd_data, 5);

        // Reset mid-frame
        for (int i = 0; i < 10; i++) send(8'($urandom));
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("t4.reset");
        rst_n = 1'b1;
        for (int i = 0; i < N_PIX; i++) send(8'(100 + i));
        chk("t4.frame_done", frame_done, 1);
        chk("t4.frame_count", frame_count, 1);
        rd(0);
        chk("t4.rd_data", rd_data, 100);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            in_valid = ($urandom_range(3) != 0);
            in_pixel = 8'($urandom);
            rel      = ($urandom_range(15) == 0);
            rd_en    = $urandom_range(1) == 1;
            rd_addr  = AW'($urandom_range(31));
            rst_n    = ($urandom_range(499) != 0);
            @(negedge clk);
        end
        in_valid = 1'b0; rel = 1'b0; rd_en = 1'b0; rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
